// File: rtl/dmem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_rr_arbiter
//   Shares the single block-wide data memory among NUM_REQ dcache cores.
//   Round-robin grant, one memory transaction in flight, and the grant is
//   held for the whole transaction (IDLE -> ISSUE -> WAIT -> DONE -> IDLE).
//
// Ports
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   req_read/write    per-core block read / write request (read wins if both)
//   req_address       packed, core i at [i*ADDR_W +: ADDR_W]
//   req_writedata     packed, core i at [i*DATA_W +: DATA_W]
//   req_busywait      per-core stall; drops only for the owner in DONE
//   req_readdata      mem_readdata broadcast to every core
//   mem_read/write    to data_memory (0 outside ISSUE/WAIT)
//   mem_address       to data_memory (0 outside ISSUE/WAIT)
//   mem_writedata     to data_memory (0 outside ISSUE/WAIT)
//   mem_busywait      from data_memory
//   mem_readdata      from data_memory
//   grant_id          current or last owner (debug)
//   timeout_err       sticky watchdog flag
//
// Build option
//   ARB_TIMEOUT_EN    when defined, WAIT is bounded by TIMEOUT_CYCLES cycles
//                     and timeout_err flags an expired transaction; when
//                     undefined, WAIT is unbounded and timeout_err is 0.
// -----------------------------------------------------------------------------
module dmem_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 28,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_busywait,
    output logic [DATA_W-1:0]           req_readdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_writedata,
    input  logic                        mem_busywait,
    input  logic [DATA_W-1:0]           mem_readdata,
    output logic [2:0]                  grant_id,
    output logic                        timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("dmem_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_grant;
    logic [2:0]          w_winner;
    logic                w_any;
    logic                w_hit;
    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_gsel;
    logic                w_g_read;
    logic                w_g_write;
    logic                w_g_req;
    logic [ADDR_W-1:0]   w_g_addr;
    logic [DATA_W-1:0]   w_g_data;
    logic                w_active;
    logic                w_timeout;

    assign w_req  = req_read | req_write;
    assign w_gsel = NUM_REQ'(1) << r_grant;

    // Rotating priority: scan from grant+NUM_REQ down to grant+1 so the last
    // hit is the first requester after the previous owner.
    always_comb begin
        w_winner = r_grant;
        w_any    = 1'b0;
        w_hit    = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_hit = |(w_req & (NUM_REQ'(1) << ((int'(r_grant) + k) % NUM_REQ)));
            if (w_hit) begin
                w_winner = 3'((int'(r_grant) + k) % NUM_REQ);
                w_any    = 1'b1;
            end
        end
    end

    // Granted core's request fields.
    always_comb begin
        w_g_addr = '0;
        w_g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gsel[i]) begin
                w_g_addr = req_address[i*ADDR_W +: ADDR_W];
                w_g_data = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_g_read  = |(req_read  & w_gsel);
    assign w_g_write = |(req_write & w_gsel);
    assign w_g_req   = w_g_read | w_g_write;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_timeout_err;

    // Counts completed WAIT cycles; fires on the TIMEOUT_CYCLES-th one.
    assign w_timeout = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wait_cnt <= 8'd0;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            // Only a genuine expiry counts: completion or abandonment wins.
            if (r_state == S_WAIT && mem_busywait && w_g_req && w_timeout)
                r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= 3'(NUM_REQ - 1);
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_any)
                r_grant <= w_winner;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                // Owner dropping its request abandons the transaction.
                if (!mem_busywait || !w_g_req || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory side is a pure mux of the owner, so reset kills it immediately.
    assign w_active      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign mem_read      = w_active & w_g_read;
    assign mem_write     = w_active & w_g_write & ~w_g_read;
    assign mem_address   = w_active ? w_g_addr : '0;
    assign mem_writedata = w_active ? w_g_data : '0;

    assign req_busywait  = w_req & ~((r_state == S_DONE) ? w_gsel : '0);
    assign req_readdata  = mem_readdata;
    assign grant_id      = r_grant;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int DW = 128;
`ifdef ARB_TIMEOUT_EN
    localparam int TO_P = 8;
    localparam int TO   = 8;
`else
    localparam int TO_P = 64;
    localparam int TO   = 1 << 30;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_address = '0;
    logic [N*DW-1:0]   req_writedata = '0;
    logic [N-1:0]      req_busywait;
    logic [DW-1:0]     req_readdata;
    logic              mem_read, mem_write;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_writedata;
    logic              mem_busywait;
    logic [DW-1:0]     mem_readdata;
    logic [2:0]        grant_id;
    logic              timeout_err;

    dmem_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO_P)) dut (
        .clock(clock), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_busywait(req_busywait), .req_readdata(req_readdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_busywait(mem_busywait), .mem_readdata(mem_readdata),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(int k);
        if (k == 16) return {16{8'hA5}};
        return {4{32'(k) * 32'h01010101}};
    endfunction

    // ---------------- data_memory stand-in ----------------
    logic [DW-1:0] mem_arr [32];
    logic [DW-1:0] rdata;
    int            lat, mcnt;
    int            force_lat = -1;

    assign mem_busywait = (mem_read | mem_write) && (mcnt < lat);
    assign mem_readdata = rdata;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mcnt  <= 0;
            lat   <= 1;
            rdata <= '0;
            for (int k = 0; k < 32; k++) mem_arr[k] <= init_word(k);
        end else if (mem_read | mem_write) begin
            mcnt <= mcnt + 1;
            if (mcnt == lat) begin
                if (mem_read) rdata <= mem_arr[mem_address[4:0]];
                else          mem_arr[mem_address[4:0]] <= mem_writedata;
            end
        end else begin
            mcnt <= 0;
            lat  <= (force_lat >= 0) ? force_lat : int'($urandom_range(1, 5));
        end
    end

    // ---------------- scoreboard + reference model ----------------
    typedef struct {
        int            core;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          sb[$];
    int            gseq[$];
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_rd [N];
    bit            rd_valid [N];
    int            nstart [N];
    int            wait_txn [N];
    bit            prev_act;
    bit            pend [N];
    int            last_g;
    int            run_len, exp_len;
    txn_t          cur;

    always @(negedge clock) begin
        bit act;
        int w, best, d, idx, wc;
        if (reset) begin
            prev_act = 1'b0;
            last_g   = N - 1;
            run_len  = 0;
            for (int k = 0; k < 32; k++) ref_mem[k] = init_word(k);
            for (int i = 0; i < N; i++) begin
                nstart[i] = 0; wait_txn[i] = 0; pend[i] = 1'b0; rd_valid[i] = 1'b0;
            end
        end else begin
            act = mem_read | mem_write;
            if (act && !prev_act) begin
                // Rotating priority: pending core closest after the last owner.
                w = -1; best = N + 1;
                for (int i = 0; i < N; i++) begin
                    d = (i - last_g - 1 + 2 * N) % N;
                    if (pend[i] && d < best) begin best = d; w = i; end
                end
                chk("grant_id_at_issue", grant_id, w);
                if (w < 0) w = int'(grant_id);
                gseq.push_back(w);
                chk("fairness_bound", wait_txn[w] <= N - 1, 1'b1);
                wait_txn[w] = 0;
                for (int i = 0; i < N; i++) if (i != w && pend[i]) wait_txn[i]++;
                idx = -1;
                foreach (sb[j]) if (idx < 0 && sb[j].core == w) idx = j;
                if (idx < 0) begin
                    chk("issue_has_request", 1'b0, 1'b1);
                    cur = '{core: w, rd: 1'b0, wr: 1'b0, addr: '0, data: '0};
                end else begin
                    cur = sb[idx];
                    sb.delete(idx);
                end
                exp_rd[w] = ref_mem[cur.addr[4:0]];
                if (cur.wr && !cur.rd) ref_mem[cur.addr[4:0]] = cur.data;
                wc = (lat < 1) ? 1 : lat;
                rd_valid[w] = (lat <= TO);
                exp_len = ((wc > TO) ? TO : wc) + 1;
                nstart[w]++;
                last_g  = w;
                run_len = 0;
            end
            if (act) begin
                run_len++;
                chk("mem_read", mem_read, cur.rd);
                chk("mem_write", mem_write, cur.wr & ~cur.rd);
                chk("mem_address", mem_address, cur.addr);
                chk("mem_writedata", mem_writedata, cur.data);
            end
            if (!act && prev_act) chk("txn_active_cycles", run_len, exp_len);
            prev_act = act;
            for (int i = 0; i < N; i++) pend[i] = req_read[i] | req_write[i];
        end
    end

    // ---------------- cache-side driver ----------------
    bit            busy [N];
    bit            myrd [N];
    int            ncomp [N];
    logic [DW-1:0] lastrd [N];
    int            issued = 0, completed = 0;
    bit            rereq = 1'b0, auto_on = 1'b0;

    task automatic issue(int i, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        req_read[i]  = rd;
        req_write[i] = wr;
        req_address[i*AW +: AW]   = a;
        req_writedata[i*DW +: DW] = d;
        busy[i] = 1'b1;
        myrd[i] = rd;
        issued++;
        sb.push_back('{core: i, rd: rd, wr: wr, addr: a, data: d});
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue_rand(int i);
        int op;
        op = int'($urandom_range(0, 2));
        issue(i, op != 1, op != 0, AW'($urandom_range(0, 31)), rnd_data());
    endtask

    task automatic step();
        bit done_now [N];
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            done_now[i] = 1'b0;
            if (busy[i] && !req_busywait[i]) begin
                chk("release_owner", grant_id, i);
                chk("release_after_start", nstart[i], ncomp[i] + 1);
                chk("release_mem_idle", {mem_read, mem_write}, 2'b00);
                if (myrd[i] && rd_valid[i]) chk("readdata", req_readdata, exp_rd[i]);
                lastrd[i] = req_readdata;
                ncomp[i]++;
                completed++;
                done_now[i] = 1'b1;
            end else if (!busy[i]) begin
                chk("idle_core_busywait", req_busywait[i], 1'b0);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (done_now[i]) begin
                req_read[i] = 1'b0; req_write[i] = 1'b0; busy[i] = 1'b0;
                if (rereq) issue(i, 1'b1, 1'b0, AW'($urandom_range(0, 31)), rnd_data());
            end
        end
        if (auto_on)
            for (int i = 0; i < N; i++)
                if (!busy[i] && $urandom_range(0, 3) == 0) issue_rand(i);
    endtask

    function automatic bit any_busy();
        for (int i = 0; i < N; i++) if (busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(string name);
        for (int c = 0; c < 600 && any_busy(); c++) step();
        chk(name, any_busy(), 1'b0);
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_mem_rw"}, {mem_read, mem_write}, 2'b00);
        chk({tag, "_mem_address"}, mem_address, '0);
        chk({tag, "_mem_writedata"}, mem_writedata, '0);
        chk({tag, "_busywait"}, req_busywait, 4'b0000);
        chk({tag, "_grant_id"}, grant_id, 3'd3);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin busy[i] = 1'b0; ncomp[i] = 0; myrd[i] = 1'b0; lastrd[i] = '0; end
        repeat (3) @(negedge clock);
        check_idle_outputs("in_reset");
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("after_reset");
        @(posedge clock); #1;

        // Cores 0,1,3 contend and keep re-requesting: 0,1,3,0.
        force_lat = 2;
        gseq.delete();
        rereq = 1'b1;
        issue(0, 1'b1, 1'b0, 28'h1, rnd_data());
        issue(1, 1'b1, 1'b0, 28'h2, rnd_data());
        issue(3, 1'b1, 1'b0, 28'h3, rnd_data());
        for (int c = 0; c < 200 && gseq.size() < 4; c++) step();
        rereq = 1'b0;
        drain("drain_contention");
        chk("rr_order_len", gseq.size() >= 4, 1'b1);
        if (gseq.size() >= 4) begin
            chk("rr_order_0", gseq[0], 0);
            chk("rr_order_1", gseq[1], 1);
            chk("rr_order_2", gseq[2], 3);
            chk("rr_order_3", gseq[3], 0);
        end

        // Core 2 read of 0x10, memory busy 4 cycles, data A5..A5.
        force_lat = 4;
        issue(2, 1'b1, 1'b0, 28'h0000010, rnd_data());
        drain("drain_core2");
        chk("core2_readdata", lastrd[2], {16{8'hA5}});
        chk("core2_grant_id", grant_id, 3'd2);

        // Core 1 write arrives while core 0 read is in flight.
        issue(0, 1'b1, 1'b0, 28'h0000005, rnd_data());
        for (int c = 0; c < 20 && !mem_read; c++) step();
        issue(1, 1'b0, 1'b1, 28'h0000004, {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978});
        drain("drain_write_during_read");

        // Randomized traffic.
        force_lat = -1;
        auto_on = 1'b1;
        repeat (400) step();
        auto_on = 1'b0;
        drain("drain_random");
        chk("all_completed", completed, issued);
        chk("scoreboard_empty", sb.size(), 0);

`ifdef ARB_TIMEOUT_EN
        force_lat = 100;
        issue(3, 1'b1, 1'b0, 28'h7, rnd_data());
        drain("drain_timeout");
        chk("timeout_err_set", timeout_err, 1'b1);
        force_lat = -1;
        repeat (5) step();
        chk("timeout_err_sticky", timeout_err, 1'b1);
`else
        chk("timeout_err_tied", timeout_err, 1'b0);
`endif

        // Reset pulse in WAIT.
        force_lat = 6;
        issue(1, 1'b1, 1'b0, 28'h9, rnd_data());
        for (int c = 0; c < 20 && !mem_read; c++) step();
        step(); step();
        chk("pre_reset_in_wait", mem_read, 1'b1);
        reset = 1'b1;
        #1;
        chk("reset_drops_mem_read", mem_read, 1'b0);
        for (int i = 0; i < N; i++) begin busy[i] = 1'b0; ncomp[i] = 0; end
        req_read = '0; req_write = '0;
        sb.delete();
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check_idle_outputs("after_reset_pulse");
        @(posedge clock); #1;
        force_lat = 1;
        issue(0, 1'b0, 1'b1, 28'h11, rnd_data());
        drain("drain_post_reset");
        chk("post_reset_grant_core0", grant_id, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
